// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter
// Single write-port scheduler for the 32x32 register file. Arbitrates the
// ALU and LSU writeback requesters onto rd_sel/rd_in/rd_w, and keeps a
// pending-load scoreboard that the issue stage queries for RAW/WAW hazards.
// The register file commits on the negedge after rf_rd_w rises, so the
// write port is registered here with a latency of one cycle.

module rf_writeback_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,

  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,

  input  logic            rsv_valid,
  input  logic [4:0]      rsv_rd,

  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  input  logic [4:0]      chk_rd,
  output logic            hazard,
  output logic [31:0]     busy,

  output logic [4:0]      rf_rd_sel,
  output logic [XLEN-1:0] rf_rd_in,
  output logic            rf_rd_w
);

  // The counter is 4 bits wide, so the limit is kept within 1..15.
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]      starve_cnt;
  logic            alu_win;
  logic            lsu_win;
  logic            alu_xfer;
  logic            lsu_xfer;
  logic            any_xfer;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [31:0]     busy_q;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;
  logic [31:0]     busy_next;

  // Pick the winner: LSU by default, ALU once it has been starved long
  // enough, and a lone requester always wins. Only valids feed this, never
  // a ready, so no combinational loop can form through the requesters.
  always_comb begin
    alu_win = 1'b0;
    lsu_win = 1'b0;
    if (alu_valid && (!lsu_valid || (starve_cnt == LIMIT))) begin
      alu_win = 1'b1;
    end else if (lsu_valid) begin
      lsu_win = 1'b1;
    end
  end

  // Readies are held low during reset so nothing is accepted while the
  // write port and scoreboard are being cleared.
  assign alu_ready = alu_win & ~rst;
  assign lsu_ready = lsu_win & ~rst;

  assign alu_xfer = alu_valid & alu_ready;
  assign lsu_xfer = lsu_valid & lsu_ready;
  assign any_xfer = alu_xfer | lsu_xfer;

  assign wb_rd   = alu_xfer ? alu_rd   : lsu_rd;
  assign wb_data = alu_xfer ? alu_data : lsu_data;

  // Count consecutive cycles the ALU is held off; saturate at the limit and
  // restart whenever the ALU gets through or stops requesting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!alu_valid || alu_xfer) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Register the write port. rd_w pulses for one cycle per accepted
  // transfer unless the target is x0; sel/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_rd_w   <= 1'b0;
      rf_rd_sel <= 5'd0;
      rf_rd_in  <= '0;
    end else if (any_xfer) begin
      rf_rd_w   <= (wb_rd != 5'd0);
      rf_rd_sel <= wb_rd;
      rf_rd_in  <= wb_data;
    end else begin
      rf_rd_w   <= 1'b0;
    end
  end

  // Build the scoreboard update: a load landing clears its bit, a new
  // reservation sets one, and set beats clear on the same register so a
  // freshly dispatched load is never lost. x0 is never tracked.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (rsv_valid && (rsv_rd != 5'd0)) begin
      set_mask[rsv_rd] = 1'b1;
    end
    if (lsu_xfer && (lsu_rd != 5'd0)) begin
      clr_mask[lsu_rd] = 1'b1;
    end
    busy_next    = (busy_q & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register; the clear lands on the same edge that raises
  // rf_rd_w, so an instruction issuing next cycle sees the committed value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign busy   = busy_q;
  assign hazard = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Testbench for rf_writeback_arbiter: a table of per-cycle vectors with
// hand-derived readies/hazard/busy, a queue of expected write-port values
// pushed when a vector is driven and popped after the following posedge,
// and hand-written sequences for reset behaviour.

module tb_rf_writeback_arbiter;

  localparam int XLEN = 32;
  localparam int NVEC = 26;

  logic            clk;
  logic            rst;
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            rsv_valid;
  logic [4:0]      rsv_rd;
  logic [4:0]      chk_rs1;
  logic [4:0]      chk_rs2;
  logic [4:0]      chk_rd;
  logic            hazard;
  logic [31:0]     busy;
  logic [4:0]      rf_rd_sel;
  logic [XLEN-1:0] rf_rd_in;
  logic            rf_rd_w;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        rv;
    logic [4:0]  rrd;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic [4:0]  cd;
    logic        exp_aready;
    logic        exp_lready;
    logic        exp_hazard;
    logic [31:0] exp_busy;
  } vec_t;

  typedef struct {
    logic        w;
    logic [4:0]  sel;
    logic [31:0] data;
  } wb_t;

  vec_t vecs [NVEC];
  wb_t  exp_q [$];

  int n_checks;
  int n_fail;

  logic [4:0]  hold_sel;
  logic [31:0] hold_data;

  rf_writeback_arbiter #(
    .STARVE_LIMIT(4),
    .XLEN(XLEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_rd(alu_rd),
    .alu_data(alu_data),
    .lsu_valid(lsu_valid),
    .lsu_ready(lsu_ready),
    .lsu_rd(lsu_rd),
    .lsu_data(lsu_data),
    .rsv_valid(rsv_valid),
    .rsv_rd(rsv_rd),
    .chk_rs1(chk_rs1),
    .chk_rs2(chk_rs2),
    .chk_rd(chk_rd),
    .hazard(hazard),
    .busy(busy),
    .rf_rd_sel(rf_rd_sel),
    .rf_rd_in(rf_rd_in),
    .rf_rd_w(rf_rd_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] adata,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
    input logic rv, input logic [4:0] rrd,
    input logic [4:0] c1, input logic [4:0] c2, input logic [4:0] cd,
    input logic ear, input logic elr, input logic ehz, input logic [31:0] ebusy);
    vec_t v;
    v.av = av; v.ard = ard; v.adata = adata;
    v.lv = lv; v.lrd = lrd; v.ldata = ldata;
    v.rv = rv; v.rrd = rrd;
    v.c1 = c1; v.c2 = c2; v.cd = cd;
    v.exp_aready = ear; v.exp_lready = elr;
    v.exp_hazard = ehz; v.exp_busy = ebusy;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    alu_valid = v.av;
    alu_rd    = v.ard;
    alu_data  = v.adata;
    lsu_valid = v.lv;
    lsu_rd    = v.lrd;
    lsu_data  = v.ldata;
    rsv_valid = v.rv;
    rsv_rd    = v.rrd;
    chk_rs1   = v.c1;
    chk_rs2   = v.c2;
    chk_rd    = v.cd;
  endtask

  // Expected write-port contents for the cycle after a vector, derived from
  // the table's own expected grant rather than from the DUT.
  task automatic pushExpected(input vec_t v);
    wb_t e;
    if (v.exp_aready) begin
      hold_sel  = v.ard;
      hold_data = v.adata;
      e.w = (v.ard != 5'd0);
    end else if (v.exp_lready) begin
      hold_sel  = v.lrd;
      hold_data = v.ldata;
      e.w = (v.lrd != 5'd0);
    end else begin
      e.w = 1'b0;
    end
    e.sel  = hold_sel;
    e.data = hold_data;
    exp_q.push_back(e);
  endtask

  initial begin
    vec_t idle;
    n_checks  = 0;
    n_fail    = 0;
    hold_sel  = 5'd0;
    hold_data = 32'd0;

    idle = mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 32'h0);

    // ALU-only write and idle follow-up
    vecs[0]  = mk(1,5,32'hDEADBEEF, 0,0,0, 0,0, 0,0,0, 1,0,0, 32'h0);
    vecs[1]  = idle;
    // Load scoreboard: reserve r10 (no same-cycle bypass), then land it
    vecs[2]  = mk(0,0,0, 0,0,0, 1,10, 10,0,0, 0,0,0, 32'h0000_0400);
    vecs[3]  = mk(0,0,0, 0,0,0, 0,0, 10,0,0, 0,0,1, 32'h0000_0400);
    vecs[4]  = mk(0,0,0, 1,10,32'h1234, 0,0, 0,10,0, 0,1,1, 32'h0);
    vecs[5]  = mk(0,0,0, 0,0,0, 0,0, 0,0,10, 0,0,0, 32'h0);
    // Contention: LSU x4, ALU on 5th, LSU again
    for (int i = 6; i <= 13; i++) begin
      vecs[i] = mk(1,3,32'hA000_0000 | 32'(i), 1,4,32'hB000_0000 | 32'(i), 0,0, 0,0,0,
                   (i == 10), (i != 10), 0, 32'h0);
    end
    // ALU drops out: starvation history must be forgotten
    vecs[14] = mk(0,0,0, 1,4,32'hB000_000E, 0,0, 0,0,0, 0,1,0, 32'h0);
    vecs[15] = mk(1,3,32'hA000_000F, 1,4,32'hB000_000F, 0,0, 0,0,0, 0,1,0, 32'h0);
    vecs[16] = mk(1,3,32'hA000_0010, 1,4,32'hB000_0010, 0,0, 0,0,0, 0,1,0, 32'h0);
    vecs[17] = mk(1,3,32'hA000_0011, 0,0,0, 0,0, 0,0,0, 1,0,0, 32'h0);
    // x0 handling and scoreboard collisions
    vecs[18] = mk(1,0,32'h55, 0,0,0, 0,0, 0,0,0, 1,0,0, 32'h0);
    vecs[19] = mk(0,0,0, 0,0,0, 1,0, 0,0,0, 0,0,0, 32'h0);
    vecs[20] = mk(0,0,0, 0,0,0, 1,7, 0,0,0, 0,0,0, 32'h0000_0080);
    vecs[21] = mk(0,0,0, 1,7,32'h77, 1,7, 0,0,7, 0,1,1, 32'h0000_0080);
    vecs[22] = mk(0,0,0, 1,7,32'h78, 1,9, 7,0,0, 0,1,1, 32'h0000_0200);
    vecs[23] = mk(0,0,0, 1,0,32'h99, 0,0, 0,9,0, 0,1,1, 32'h0000_0200);
    // Set up rf_rd_w=1 with busy=0x400 for the async reset check
    vecs[24] = mk(0,0,0, 0,0,0, 1,10, 0,0,0, 0,0,0, 32'h0000_0600);
    vecs[25] = mk(0,0,0, 1,9,32'hCAFE, 0,0, 10,0,0, 0,1,1, 32'h0000_0400);

    // Reset with both requesters valid: nothing may be granted
    rst = 1'b1;
    applyStimulus(idle);
    alu_valid = 1'b1;
    lsu_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", busy, 32'h0);
    checkOutput("reset rf_rd_w", 32'(rf_rd_w), 32'h0);
    checkOutput("reset rf_rd_sel", 32'(rf_rd_sel), 32'h0);
    checkOutput("reset rf_rd_in", rf_rd_in, 32'h0);
    checkOutput("reset alu_ready", 32'(alu_ready), 32'h0);
    checkOutput("reset lsu_ready", 32'(lsu_ready), 32'h0);
    @(negedge clk);
    applyStimulus(idle);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      wb_t got;
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].exp_aready));
      checkOutput($sformatf("v%0d lsu_ready", i), 32'(lsu_ready), 32'(vecs[i].exp_lready));
      checkOutput($sformatf("v%0d hazard", i), 32'(hazard), 32'(vecs[i].exp_hazard));
      pushExpected(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d busy", i), busy, vecs[i].exp_busy);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL v%0d scoreboard: got empty queue, expected an entry", i);
      end else begin
        got = exp_q.pop_front();
        checkOutput($sformatf("v%0d rf_rd_w", i), 32'(rf_rd_w), 32'(got.w));
        checkOutput($sformatf("v%0d rf_rd_sel", i), 32'(rf_rd_sel), 32'(got.sel));
        checkOutput($sformatf("v%0d rf_rd_in", i), rf_rd_in, got.data);
      end
    end

    // Async reset mid-cycle while a write is pending: no edge needed
    applyStimulus(idle);
    #2;
    rst = 1'b1;
    alu_valid = 1'b1;
    lsu_valid = 1'b1;
    #1;
    checkOutput("async rf_rd_w", 32'(rf_rd_w), 32'h0);
    checkOutput("async busy", busy, 32'h0);
    checkOutput("async rf_rd_sel", 32'(rf_rd_sel), 32'h0);
    checkOutput("async rf_rd_in", rf_rd_in, 32'h0);
    checkOutput("async alu_ready", 32'(alu_ready), 32'h0);
    checkOutput("async lsu_ready", 32'(lsu_ready), 32'h0);

    // Release reset: readies follow the valids again
    @(negedge clk);
    rst = 1'b0;
    lsu_valid = 1'b0;
    #1;
    checkOutput("post-reset alu_ready", 32'(alu_ready), 32'h1);
    checkOutput("post-reset lsu_ready idle", 32'(lsu_ready), 32'h0);
    lsu_valid = 1'b1;
    #1;
    checkOutput("post-reset lsu_ready", 32'(lsu_ready), 32'h1);
    checkOutput("post-reset alu_ready denied", 32'(alu_ready), 32'h0);
    #1;
    applyStimulus(idle);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
Sole write-port scheduler for the 32x32 register file. Arbitrates the ALU and LSU writeback requesters onto the single write port (rd_sel/rd_in/rd_w) and keeps a pending-load scoreboard. The issue stage queries the scoreboard for RAW/WAW hazards. Sits between execute/memory stages and the register file; the register file commits on the negedge following a write-port assertion.

Parameters:
STARVE_LIMIT, 4, consecutive cycles the ALU may be denied while valid before it takes priority over the LSU (1..15)
XLEN, 32, data width

Ports:
clk  input  1  core clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU request accepted this cycle (combinational)
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result
lsu_valid  input  1  LSU (load) writeback request
lsu_ready  output  1  LSU request accepted this cycle (combinational)
lsu_rd  input  5  load destination register
lsu_data  input  XLEN  load data
rsv_valid  input  1  issue stage dispatches a load; reserve rsv_rd
rsv_rd  input  5  register to mark busy
chk_rs1  input  5  issue-stage source 1 to check
chk_rs2  input  5  issue-stage source 2 to check
chk_rd  input  5  issue-stage destination to check (WAW)
hazard  output  1  any checked register busy (combinational)
busy  output  32  scoreboard bit vector; bit 0 always 0
rf_rd_sel  output  5  to register file rd_sel
rf_rd_in  output  XLEN  to register file rd_in
rf_rd_w  output  1  to register file rd_w

Behaviour:
- Reset (async, rst=1): busy=0, rf_rd_w=0, rf_rd_sel=0, rf_rd_in=0, starvation counter=0. All reservations are dropped. alu_ready/lsu_ready read 0 while rst is high.
- Transfer occurs on a posedge where valid&&ready. At most one transfer per cycle.
- Arbitration (combinational):
  - Default priority is LSU over ALU.
  - If starve_cnt==STARVE_LIMIT, ALU wins.
  - A sole valid requester always wins.
  - ready is asserted to the winner only. ready never depends on a ready input, so there is no combinational loop.
- Starvation counter (4-bit):
  - Increments when alu_valid && !alu_ready.
  - Clears on ALU transfer or when alu_valid=0.
  - Saturates at STARVE_LIMIT.
- Output register, latency 1:
  - On a transfer, rf_rd_sel<=rd and rf_rd_in<=data on the next posedge.
  - rf_rd_w<=(rd!=0) for exactly that one cycle. The register file commits at the following negedge.
  - With no transfer, rf_rd_w<=0. rf_rd_sel and rf_rd_in hold their previous values.
- rd=0: the handshake completes normally, but rf_rd_w stays 0 and the scoreboard is untouched.
- Scoreboard set: on posedge with rsv_valid && rsv_rd!=0, set busy[rsv_rd].
- Scoreboard clear: on posedge with an LSU transfer, clear busy[lsu_rd]. This is the same edge on which rf_rd_w rises, so a consumer issuing next cycle reads the committed value.
- ALU transfers never clear busy.
- Simultaneous set and clear of the same register: set wins (new load reserved). Different registers: both apply.
- Reserving an already-busy register: the bit stays 1 (single bit). The issue stage must stall on hazard via chk_rd.
- An LSU write to a non-busy register is committed normally; busy is unchanged.
- hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd], using current registered busy. There is no bypass of same-cycle sets or clears.
- Reset mid-transfer: a pending rf_rd_w is cancelled immediately (async) and the write is lost.

Test Plan:
1. ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 same cycle. Next cycle rf_rd_w=1, rf_rd_sel=5, rf_rd_in=0xDEADBEEF. The cycle after, rf_rd_w=0.
2. Load scoreboard: rsv_valid=1, rsv_rd=10 -> busy[10]=1 next cycle and hazard=1 with chk_rs1=10. LSU transfer lsu_rd=10, data=0x1234 -> busy[10]=0 on the edge where rf_rd_w=1 and rf_rd_sel=10.
3. Contention: both valid continuously, STARVE_LIMIT=4 -> LSU granted 4 cycles, ALU granted on the 5th, then the counter clears and the LSU is granted again.
4. x0 and collisions:
   - alu_rd=0 -> alu_ready=1, rf_rd_w stays 0.
   - rsv_rd=0 -> busy stays 0.
   - rsv_rd=7 in the same cycle as LSU transfer lsu_rd=7 (busy[7] previously 1) -> busy[7] remains 1.
5. Async reset: assert rst mid-cycle while rf_rd_w=1 and busy=0x00000400 -> rf_rd_w, busy, rf_rd_sel, rf_rd_in go to 0 immediately without a clock edge. Deassert -> both readies follow the valids.
